// File: rtl/mcpu_mem_il1.sv
// ============================================================================
// mcpu_mem_il1 -- instruction L1 cache for the MCPU memory subsystem.
//
// Set-associative, read-only cache with 32-byte lines. A fetch is accepted in
// IDLE and looked up one cycle later. A hit returns the requested 16-byte
// half-line in that lookup cycle. A miss fetches the line as two 16-byte beats
// over the fill interface, installs it in a victim way (the lowest invalid
// way, otherwise the set's round-robin way) and then returns the requested
// half.
//
// Ports
//   clkrst_mem_clk    in   1    clock, rising edge
//   clkrst_mem_rst_n  in   1    asynchronous active-low reset
//   mem_inst_ppg      in   17   physical page, paddr[28:12]
//   mem_inst_vpg      in   20   virtual page (not used by this cache)
//   mem_inst_ppo      in   12   page offset, paddr[11:0]
//   mem_inst_req      in   1    fetch request, taken only in IDLE
//   mem_inst_mdr      out  128  fetched half-line, zero while rdy is low
//   mem_inst_rdy      out  1    one-cycle pulse, mdr valid
//   mem_inst_flush    in   1    invalidate every line
//   il1_fill_addr     out  24   line address paddr[28:5], zero when idle
//   il1_fill_req      out  1    fill request, held until acked
//   il1_fill_ack      in   1    fill request accepted
//   il1_fill_valid    in   1    fill beat valid
//   il1_fill_data     in   128  fill beat (beat 0 = bytes 0-15)
// ============================================================================
module mcpu_mem_il1 #(
   parameter int WAYS      = 4,
   parameter int WAYS_BITS = 2,
   parameter int SETS      = 32,
   parameter int SET_BITS  = 5
) (
   input  logic          clkrst_mem_clk,
   input  logic          clkrst_mem_rst_n,
   input  logic [16:0]   mem_inst_ppg,
   input  logic [19:0]   mem_inst_vpg,
   input  logic [11:0]   mem_inst_ppo,
   input  logic          mem_inst_req,
   output logic [127:0]  mem_inst_mdr,
   output logic          mem_inst_rdy,
   input  logic          mem_inst_flush,
   output logic [23:0]   il1_fill_addr,
   output logic          il1_fill_req,
   input  logic          il1_fill_ack,
   input  logic          il1_fill_valid,
   input  logic [127:0]  il1_fill_data
);

   localparam int TAG_W = 24 - SET_BITS;
   // A direct-mapped build still needs a 1-bit way index to stay legal.
   localparam int PTR_W = (WAYS_BITS > 0) ? WAYS_BITS : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_FILL_REQ,
      S_FILL_WAIT,
      S_RESPOND
   } state_t;

   state_t            state_q, state_d;
   logic [28:4]       paddr_q;          // byte offset [3:0] never matters
   logic [PTR_W-1:0]  victim_q;
   logic              evict_valid_q;    // victim held a valid line
   logic              beat_q;           // next fill beat index
   logic              flush_pend_q;     // flush seen while a fill was running

   logic [WAYS-1:0]   valid_q [SETS];
   logic [PTR_W-1:0]  ptr_q   [SETS];
   logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
   logic [255:0]      data_q  [SETS][WAYS];

   logic [SET_BITS-1:0] set_idx;
   logic [TAG_W-1:0]    tag_cur;
   logic [WAYS-1:0]     hit_vec;
   logic                hit;
   logic [PTR_W-1:0]    hit_way, inv_way, victim_d, ptr_next, rd_way;
   logic                inv_found;
   logic [255:0]        rd_line;
   logic [127:0]        rd_half;
   logic                rdy, fill_req, clear_all, fill_done;

   // The virtual page and the byte offset inside a half-line play no part.
   logic unused_inputs;
   assign unused_inputs = ^{mem_inst_vpg, mem_inst_ppo[3:0]};

   assign set_idx = paddr_q[SET_BITS+4:5];
   assign tag_cur = paddr_q[28:SET_BITS+5];

   // ---------------------------------------------------------------------
   // Tag compare and victim choice for the registered address.
   // ---------------------------------------------------------------------
   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      hit_vec   = '0;
      hit_way   = '0;
      inv_way   = '0;
      inv_found = 1'b0;
      // Walking downwards lets the lowest index win both encoders.
      for (int w = WAYS - 1; w >= 0; w--) begin
         hit_vec[w] = valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_cur);
         if (hit_vec[w]) begin
            hit_way = PTR_W'(w);
         end
         if (!valid_q[set_idx][w]) begin
            inv_way   = PTR_W'(w);
            inv_found = 1'b1;
         end
      end
   end

   assign hit      = |hit_vec;
   assign victim_d = inv_found ? inv_way : ptr_q[set_idx];
   // WAYS is a power of two, so wrapping the PTR_W-bit add is mod WAYS.
   assign ptr_next = (WAYS == 1) ? '0 : ptr_q[set_idx] + 1'b1;

   // The lookup reads the hitting way; the response reads the way just filled.
   assign rd_way  = (state_q == S_LOOKUP) ? hit_way : victim_q;
   assign rd_line = data_q[set_idx][rd_way];
   assign rd_half = paddr_q[4] ? rd_line[255:128] : rd_line[127:0];

   // ---------------------------------------------------------------------
   // Next state and outputs.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      rdy       = 1'b0;
      fill_req  = 1'b0;
      clear_all = 1'b0;
      fill_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Flush beats a simultaneous request; the core re-presents it.
            if (mem_inst_flush) begin
               clear_all = 1'b1;
            end else if (mem_inst_req) begin
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (mem_inst_flush) begin
               clear_all = 1'b1;
               state_d   = S_IDLE;
            end else if (hit) begin
               rdy     = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_FILL_REQ;
            end
         end
         S_FILL_REQ: begin
            fill_req = 1'b1;
            if (il1_fill_ack) begin
               state_d = S_FILL_WAIT;
            end
         end
         S_FILL_WAIT: begin
            if (il1_fill_valid && beat_q) begin
               fill_done = 1'b1;
               state_d   = S_RESPOND;
            end
         end
         S_RESPOND: begin
            // A flush that arrived during the fill is honoured only now, after
            // the requested data has been returned.
            rdy       = 1'b1;
            clear_all = flush_pend_q || mem_inst_flush;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign mem_inst_rdy  = rdy;
   assign mem_inst_mdr  = rdy ? rd_half : '0;
   assign il1_fill_req  = fill_req;
   assign il1_fill_addr = fill_req ? paddr_q[28:5] : '0;

   // ---------------------------------------------------------------------
   // Control registers.
   // ---------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so every register
   // samples its inputs from before the edge, independent of block order.
   always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
      if (!clkrst_mem_rst_n) begin
         state_q       <= S_IDLE;
         paddr_q       <= '0;
         victim_q      <= '0;
         evict_valid_q <= 1'b0;
         beat_q        <= 1'b0;
         flush_pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && mem_inst_req && !mem_inst_flush) begin
            paddr_q <= {mem_inst_ppg, mem_inst_ppo[11:4]};
         end
         if (state_q == S_LOOKUP) begin
            victim_q      <= victim_d;
            evict_valid_q <= !inv_found;
         end
         // A beat presented together with the ack is not counted.
         if (state_q == S_FILL_REQ) begin
            beat_q <= 1'b0;
         end else if (state_q == S_FILL_WAIT && il1_fill_valid) begin
            beat_q <= 1'b1;
         end
         if ((state_q == S_FILL_REQ || state_q == S_FILL_WAIT) && mem_inst_flush) begin
            flush_pend_q <= 1'b1;
         end else if (state_q == S_RESPOND) begin
            flush_pend_q <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Valid bits and round-robin pointers.
   // ---------------------------------------------------------------------
   always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
      if (!clkrst_mem_rst_n) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            ptr_q[s]   <= '0;
         end
      end else if (clear_all) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            ptr_q[s]   <= '0;
         end
      end else if (fill_done) begin
         valid_q[set_idx][victim_q] <= 1'b1;
         // Filling a previously empty way leaves the rotation untouched.
         if (evict_valid_q) begin
            ptr_q[set_idx] <= ptr_next;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Tag and data storage.
   // ---------------------------------------------------------------------
   // NOTE: tag and data arrays have no reset; the reset valid bits already
   // make every entry unusable, and an unreset array maps onto plain RAM.
   always_ff @(posedge clkrst_mem_clk) begin
      if (state_q == S_FILL_WAIT && il1_fill_valid) begin
         if (beat_q) begin
            data_q[set_idx][victim_q][255:128] <= il1_fill_data;
            tag_q[set_idx][victim_q]           <= tag_cur;
         end else begin
            data_q[set_idx][victim_q][127:0] <= il1_fill_data;
         end
      end
   end

endmodule

// File: tb/tb_mcpu_mem_il1.sv
// ============================================================================
// tb_mcpu_mem_il1 -- directed bench for mcpu_mem_il1 plus a random fetch
// stream on a direct-mapped/2-set and an 8-way/128-set build.
// Main instance (4 ways, 32 sets) is driven cycle by cycle; the two sweep
// instances each have a memory responder whose line contents are a fixed
// function of the line address, so every returned half-line has a known value.
// ============================================================================
module tb_mcpu_mem_il1;

   logic          clk;
   logic          rst_n;
   logic [16:0]   ppg;
   logic [19:0]   vpg;
   logic [11:0]   ppo;
   logic          req, flush, ack, fvalid;
   logic [127:0]  fdata, mdr;
   logic          rdy, freq;
   logic [23:0]   faddr;

   logic          sw_req, sw_flush;
   logic [16:0]   sw_ppg;
   logic [11:0]   sw_ppo;
   logic [127:0]  s1_mdr, s8_mdr, s1_data, s8_data;
   logic          s1_rdy, s8_rdy, s1_freq, s8_freq;
   logic          s1_ack, s8_ack, s1_valid, s8_valid;
   logic [23:0]   s1_faddr, s8_faddr;

   int checks = 0;
   int errors = 0;
   int multi_hits = 0;

   mcpu_mem_il1 #(.WAYS(4), .WAYS_BITS(2), .SETS(32), .SET_BITS(5)) dut (
      .clkrst_mem_clk(clk), .clkrst_mem_rst_n(rst_n),
      .mem_inst_ppg(ppg), .mem_inst_vpg(vpg), .mem_inst_ppo(ppo),
      .mem_inst_req(req), .mem_inst_mdr(mdr), .mem_inst_rdy(rdy),
      .mem_inst_flush(flush), .il1_fill_addr(faddr), .il1_fill_req(freq),
      .il1_fill_ack(ack), .il1_fill_valid(fvalid), .il1_fill_data(fdata));

   mcpu_mem_il1 #(.WAYS(1), .WAYS_BITS(0), .SETS(2), .SET_BITS(1)) s1 (
      .clkrst_mem_clk(clk), .clkrst_mem_rst_n(rst_n),
      .mem_inst_ppg(sw_ppg), .mem_inst_vpg(vpg), .mem_inst_ppo(sw_ppo),
      .mem_inst_req(sw_req), .mem_inst_mdr(s1_mdr), .mem_inst_rdy(s1_rdy),
      .mem_inst_flush(sw_flush), .il1_fill_addr(s1_faddr), .il1_fill_req(s1_freq),
      .il1_fill_ack(s1_ack), .il1_fill_valid(s1_valid), .il1_fill_data(s1_data));

   mcpu_mem_il1 #(.WAYS(8), .WAYS_BITS(3), .SETS(128), .SET_BITS(7)) s8 (
      .clkrst_mem_clk(clk), .clkrst_mem_rst_n(rst_n),
      .mem_inst_ppg(sw_ppg), .mem_inst_vpg(vpg), .mem_inst_ppo(sw_ppo),
      .mem_inst_req(sw_req), .mem_inst_mdr(s8_mdr), .mem_inst_rdy(s8_rdy),
      .mem_inst_flush(sw_flush), .il1_fill_addr(s8_faddr), .il1_fill_req(s8_freq),
      .il1_fill_ack(s8_ack), .il1_fill_valid(s8_valid), .il1_fill_data(s8_data));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Directed fill payload: k identifies the fill, b the beat.
   function automatic logic [127:0] pat(input int k, input logic b);
      return {64'hC0FF_EE00_0000_0000 | 64'(k), 63'h0, b};
   endfunction

   // Backing-memory contents for the sweep instances.
   function automatic logic [127:0] mem_word(input logic [23:0] la, input logic b);
      logic [31:0] h;
      h = {8'h0, la} * 32'h9E37_79B1;
      return {la, 7'h55, b, h, h ^ 32'hDEAD_BEEF, ~{8'h0, la}};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Miss with a full fill; a junk beat rides along with the ack and must be
   // ignored. flush_mid raises flush during beat 0.
   task automatic fetch_miss(input string tag, input logic [28:0] pa,
                             input logic [127:0] a, input logic [127:0] b,
                             input logic flush_mid);
      step();
      req = 1'b1; ppg = pa[28:12]; ppo = pa[11:0];
      step();
      req = 1'b0;
      @(negedge clk);
      check({tag, "_lookup_rdy"}, 128'(rdy), 128'(0));
      step();
      @(negedge clk);
      check({tag, "_fill_req"}, 128'(freq), 128'(1));
      check({tag, "_fill_addr"}, 128'(faddr), 128'(pa[28:5]));
      ack = 1'b1; fvalid = 1'b1; fdata = {4{32'hBAD0_BAD0}};
      step();
      ack = 1'b0; fvalid = 1'b1; fdata = a; flush = flush_mid;
      step();
      flush = 1'b0; fdata = b;
      step();
      fvalid = 1'b0;
      @(negedge clk);
      check({tag, "_resp_rdy"}, 128'(rdy), 128'(1));
      check({tag, "_resp_mdr"}, mdr, pa[4] ? b : a);
      step();
      @(negedge clk);
      check({tag, "_rdy_pulse"}, 128'(rdy), 128'(0));
   endtask

   task automatic fetch_hit(input string tag, input logic [28:0] pa, input logic [127:0] exp);
      step();
      req = 1'b1; ppg = pa[28:12]; ppo = pa[11:0];
      step();
      req = 1'b0;
      @(negedge clk);
      check({tag, "_hit_rdy"}, 128'(rdy), 128'(1));
      check({tag, "_hit_mdr"}, mdr, exp);
   endtask

   // Two valid ways matching one tag would be a corrupted cache.
   always @(negedge clk) begin
      if (rst_n && ($countones(dut.hit_vec) > 1 || $countones(s8.hit_vec) > 1)) begin
         multi_hits++;
      end
   end

   // Memory responder for the direct-mapped build.
   initial begin : s1_mem
      logic [23:0] la;
      s1_ack = 1'b0; s1_valid = 1'b0; s1_data = '0;
      forever begin
         @(negedge clk);
         if (s1_freq) begin
            la = s1_faddr;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            s1_ack = 1'b1;
            @(negedge clk);
            s1_ack = 1'b0;
            for (int b = 0; b < 2; b++) begin
               repeat ($urandom_range(0, 1)) @(negedge clk);
               s1_valid = 1'b1; s1_data = mem_word(la, b[0]);
               @(negedge clk);
               s1_valid = 1'b0;
            end
         end
      end
   end

   // Memory responder for the 8-way build.
   initial begin : s8_mem
      logic [23:0] la;
      s8_ack = 1'b0; s8_valid = 1'b0; s8_data = '0;
      forever begin
         @(negedge clk);
         if (s8_freq) begin
            la = s8_faddr;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            s8_ack = 1'b1;
            @(negedge clk);
            s8_ack = 1'b0;
            for (int b = 0; b < 2; b++) begin
               repeat ($urandom_range(0, 1)) @(negedge clk);
               s8_valid = 1'b1; s8_data = mem_word(la, b[0]);
               @(negedge clk);
               s8_valid = 1'b0;
            end
         end
      end
   end

   initial begin : main
      logic [28:0]  pa;
      logic [127:0] e;
      logic         got1, got8;

      rst_n = 1'b0; ppg = '0; vpg = '0; ppo = '0; req = 1'b0; flush = 1'b0;
      ack = 1'b0; fvalid = 1'b0; fdata = '0;
      sw_req = 1'b0; sw_flush = 1'b0; sw_ppg = '0; sw_ppo = '0;

      // Reset values.
      repeat (2) @(negedge clk);
      check("rst_rdy", 128'(rdy), 128'(0));
      check("rst_fill_req", 128'(freq), 128'(0));
      check("rst_fill_addr", 128'(faddr), 128'(0));
      check("rst_mdr", mdr, 128'(0));
      rst_n = 1'b1;

      // Cold miss to 0x120 (line 0x9), then both halves hit.
      fetch_miss("cold", 29'h120, pat(0, 0), pat(0, 1), 1'b0);
      fetch_hit("rehit_hi", 29'h130, pat(0, 1));
      fetch_hit("rehit_lo", 29'h120, pat(0, 0));

      // Five tags into set 3: the fifth evicts way 0 (tag 1).
      for (int k = 1; k <= 5; k++) begin
         fetch_miss($sformatf("set3_t%0d", k), 29'(k * 32'h400 + 32'h60), pat(k, 0), pat(k, 1), 1'b0);
      end
      fetch_hit("set3_t5", 29'h1470, pat(5, 1));
      fetch_hit("set3_t2", 29'h0860, pat(2, 0));
      fetch_miss("set3_t1_evicted", 29'h0460, pat(6, 0), pat(6, 1), 1'b0);
      fetch_hit("other_set", 29'h120, pat(0, 0));

      // Flush in IDLE: previously hitting lines miss.
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      fetch_miss("flush_t5", 29'h1460, pat(7, 0), pat(7, 1), 1'b0);
      fetch_miss("flush_cold", 29'h120, pat(0, 0), pat(0, 1), 1'b0);

      // Flush together with req in IDLE: request is not taken.
      step();
      req = 1'b1; flush = 1'b1; ppg = 17'h0; ppo = 12'h460;
      step();
      req = 1'b0; flush = 1'b0;
      @(negedge clk);
      check("flush_req_rdy", 128'(rdy), 128'(0));
      step();
      @(negedge clk);
      check("flush_req_not_taken", 128'(freq), 128'(0));
      fetch_miss("reissue", 29'h460, pat(8, 0), pat(8, 1), 1'b0);

      // Flush during LOOKUP of a hitting line drops the response.
      step();
      req = 1'b1; ppg = 17'h0; ppo = 12'h460;
      step();
      req = 1'b0; flush = 1'b1;
      @(negedge clk);
      check("lookup_flush_rdy", 128'(rdy), 128'(0));
      step();
      flush = 1'b0;
      @(negedge clk);
      check("lookup_flush_idle", 128'(freq), 128'(0));
      fetch_miss("after_lookup_flush", 29'h460, pat(9, 0), pat(9, 1), 1'b0);

      // Flush during FILL_WAIT: response still delivered, then all lines gone.
      fetch_miss("fillwait_flush", 29'h2010, pat(10, 0), pat(10, 1), 1'b1);
      fetch_miss("fw_flush_other", 29'h460, pat(11, 0), pat(11, 1), 1'b0);
      fetch_miss("fw_flush_same", 29'h2010, pat(12, 0), pat(12, 1), 1'b0);

      // Reset between beat 0 and beat 1.
      step();
      req = 1'b1; ppg = 17'h0; ppo = 12'h120;
      step();
      req = 1'b0;
      step();
      @(negedge clk);
      check("rst_mid_fill_req", 128'(freq), 128'(1));
      ack = 1'b1;
      step();
      ack = 1'b0; fvalid = 1'b1; fdata = pat(13, 0);
      step();
      fdata = pat(13, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_rdy", 128'(rdy), 128'(0));
      check("rst_mid_fill_req_low", 128'(freq), 128'(0));
      check("rst_mid_fill_addr", 128'(faddr), 128'(0));
      check("rst_mid_mdr", mdr, 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      step();
      fvalid = 1'b0;
      @(negedge clk);
      check("late_beat_rdy", 128'(rdy), 128'(0));
      check("late_beat_fill_req", 128'(freq), 128'(0));
      fetch_miss("post_reset_miss", 29'h120, pat(14, 0), pat(14, 1), 1'b0);

      // Random fetch stream on the 1-way/2-set and 8-way/128-set builds.
      for (int n = 0; n < 80; n++) begin
         pa = 29'(($urandom_range(0, 11) << 12) | ($urandom_range(0, 3) << 5) |
                  ($urandom_range(0, 1) << 4) | $urandom_range(0, 15));
         e = mem_word(pa[28:5], pa[4]);
         step();
         sw_req = 1'b1; sw_ppg = pa[28:12]; sw_ppo = pa[11:0];
         step();
         sw_req = 1'b0;
         got1 = 1'b0;
         got8 = 1'b0;
         for (int c = 0; c < 40 && !(got1 && got8); c++) begin
            @(negedge clk);
            if (s1_rdy && !got1) begin
               got1 = 1'b1;
               check($sformatf("sweep_w1_%0d", n), s1_mdr, e);
            end
            if (s8_rdy && !got8) begin
               got8 = 1'b1;
               check($sformatf("sweep_w8_%0d", n), s8_mdr, e);
            end
         end
         check($sformatf("sweep_w1_done_%0d", n), 128'(got1), 128'(1));
         check($sformatf("sweep_w8_done_%0d", n), 128'(got8), 128'(1));
      end

      check("multi_way_hit", 128'(multi_hits), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mcpu_mem_il1.md
MCPU_MEM_IL1 -- requirements
Module: MCPU_MEM_il1

Interface
REQ-001 Parameter WAYS, default 4, associativity; legal values 1, 2, 4 or 8.
REQ-002 Parameter WAYS_BITS, default 2, log2(WAYS); 0 when WAYS=1.
REQ-003 Parameter SETS, default 32, set count; power of two from 2 to 128.
REQ-004 Parameter SET_BITS, default 5, log2(SETS); line size fixed at 32 B; set = paddr[SET_BITS+4:5]; tag = paddr[28:SET_BITS+5].
REQ-005 clkrst_mem_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 clkrst_mem_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 mem_inst_ppg  in  17  physical page, paddr[28:12].
REQ-008 mem_inst_vpg  in  20  virtual page; unused, port retained for core compatibility.
REQ-009 mem_inst_ppo  in  12  page offset, paddr[11:0].
REQ-010 mem_inst_req  in  1  fetch request; sampled only in IDLE.
REQ-011 mem_inst_mdr  out  128  fetched 16-byte half-line.
REQ-012 mem_inst_rdy  out  1  one-cycle pulse, mdr valid.
REQ-013 mem_inst_flush  in  1  invalidate all lines.
REQ-014 il1_fill_addr  out  24  line address paddr[28:5].
REQ-015 il1_fill_req  out  1  fill request; held until acked.
REQ-016 il1_fill_ack  in  1  fill request accepted this cycle.
REQ-017 il1_fill_valid  in  1  fill beat valid.
REQ-018 il1_fill_data  in  128  fill beat; beat 0 = bytes 0-15, beat 1 = bytes 16-31.

Function
REQ-019 Storage: per set, WAYS entries of {valid, tag, 256-bit data}, plus a WAYS_BITS round-robin victim pointer.
REQ-020 States: IDLE, LOOKUP, FILL_REQ, FILL_WAIT, RESPOND.
REQ-021 IDLE, req=1 and flush=0: register paddr={ppg,ppo} and go to LOOKUP.
REQ-022 LOOKUP, hit (valid and tag match in exactly one way): mdr = half-line selected by paddr[4], rdy=1 this cycle, go to IDLE; hit latency is 1 cycle after req is sampled.
REQ-023 LOOKUP, miss: go to FILL_REQ; the victim is the first invalid way (lowest index), else the way at the set's round-robin pointer.
REQ-024 FILL_REQ: fill_req=1, fill_addr=paddr[28:5]; on fill_ack, go to FILL_WAIT.
REQ-025 FILL_WAIT: each fill_valid writes the next beat into the victim data; valid_in the same cycle as ack is ignored; after beat 1, write tag, set valid, advance the set pointer (mod WAYS) only if a valid way was evicted, then go to RESPOND.
REQ-026 RESPOND: rdy=1, mdr = requested half from the just-filled line, go to IDLE; miss latency is 1 cycle after the last beat.
REQ-027 rdy is 0 in all cycles except those in REQ-022 and REQ-026; mdr is don't-care while rdy=0.
REQ-028 Flush in IDLE or LOOKUP: clear all valid bits and pointers next edge; any pending lookup is dropped with no rdy; state returns to IDLE.
REQ-029 Flush during FILL_REQ/FILL_WAIT: recorded; fill completes and responds, then all valid bits are cleared on the RESPOND edge.
REQ-030 Flush and req together in IDLE: flush wins; req is not accepted and must be re-presented.
REQ-031 req is ignored outside IDLE; the core holds inputs until rdy.
REQ-032 Multiple-way hit cannot occur; the bench asserts this.

Reset
REQ-033 While rst_n=0: state=IDLE, all valid=0, pointers=0, rdy=0, fill_req=0, fill_addr=0, mdr=0.
REQ-034 Reset mid-fill abandons the fill; the victim way stays invalid; late fill beats after reset are ignored in IDLE.

Verification
REQ-035 Cold miss to paddr 0x0000120: fill_req with fill_addr=0x000009; ack; beats A and B; rdy with mdr=A one cycle after B; re-fetching 0x0000130 hits, giving mdr=B one cycle after req.
REQ-036 WAYS=4: five distinct tags to set 3; the fifth miss evicts way 0, and re-fetching the first tag misses.
REQ-037 Flush after fills: each previously hitting address misses and issues fill_req.
REQ-038 Flush asserted in FILL_WAIT: the response is still delivered, then the same address misses.
REQ-039 rst_n pulled low between beat 0 and beat 1: outputs reach reset values immediately; the next fetch to that line misses.
REQ-040 Parameter sweep WAYS in {1,8} and SETS in {2,128}: random fetch stream, where every rdy matches the reference-model memory contents.
